lru_cam_ctrl: RTL and testbench
===============================

Name: lru_cam_ctrl

Overview:
- Request-side controller for the LRU content-addressable store.
- Accepts one key per request handshake and searches all entries in parallel.
- On a hit, promotes the matching entry to position 0 (most recent). On a miss, inserts the key at position 0, shifts the others down and evicts the entry in the last position.
- Returns hit/miss, hit index and evicted key through a response handshake.

Parameters:
- DEPTH, 8, number of entries; must be ≥2. Position 0 is most recent; position DEPTH-1 is least recent.
- DATA_W, 8, key width in bits.
- IDX_W, $clog2(DEPTH), derived localparam (not overridable); width of all index fields.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  a lookup key is present.
- req_ready  output  1  controller is able to accept a key.
- req_data  input  DATA_W  key to look up or insert.
- resp_valid  output  1  a response is present.
- resp_ready  input  1  the consumer accepts the response.
- resp_hit  output  1  1 = key was found.
- resp_index  output  IDX_W  position where the key was found before promotion; 0 on a miss.
- resp_evict_valid  output  1  a valid entry was pushed out on a miss.
- resp_evict_data  output  DATA_W  the evicted key.
- occupancy  output  IDX_W+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (asynchronous, active low):
  - All entry data cleared to 0; all valid bits cleared to 0.
  - State goes to IDLE.
  - req_ready=1; resp_valid=0, resp_hit=0, resp_index=0, resp_evict_valid=0, resp_evict_data=0, occupancy=0.
  - A reset during any state abandons the operation; no partial shift is retained.
- State machine:
  - IDLE: req_ready=1. On req_valid&&req_ready, register the key and go to LOOKUP.
  - LOOKUP: compare the key with every entry whose valid bit is set. A match is data equality AND valid. Register hit and index, with the lowest index winning (duplicates are not possible by construction). Go to UPDATE.
  - UPDATE, on a hit at index k:
    - Entries 0..k-1 move to 1..k; the key is written to 0.
    - Entries above k are unchanged; occupancy is unchanged.
    - k=0 leaves the array unchanged.
  - UPDATE, on a miss:
    - Entries 0..DEPTH-2 move to 1..DEPTH-1; the key is written to 0 with valid=1.
    - The old entry at DEPTH-1 is captured as the evict data, with evict_valid equal to its valid bit.
    - occupancy increments, saturating at DEPTH.
    - Go to RESP.
  - RESP: resp_valid=1 and all resp_* fields are held stable until resp_ready. On resp_valid&&resp_ready, go to IDLE.
- Timing:
  - Key accepted at edge t0.
  - resp_valid rises after edge t0+2.
  - The array is already updated when resp_valid rises.
  - Minimum spacing between accepted requests is 4 cycles. req_ready is 0 in LOOKUP, UPDATE and RESP.
- Response fields:
  - resp_* fields take their new values only on entry to RESP.
  - Between responses they hold their last values; resp_valid qualifies them.
- An empty array always misses. Key value 0 is a legal key; validity comes only from the valid bits.

Optional Feature:
- Macro: LRU_CAM_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 sampled in IDLE clears all valid bits and sets occupancy to 0 at that edge. Data is not cleared.
  - If flush and req_valid are both high in IDLE, flush wins and req_ready is 0 that cycle.
  - flush is ignored outside IDLE.
- When undefined: no flush port and no flush logic.

Decomposition:
- Shared package lru_cam_pkg holds:
  - the state enum {IDLE, LOOKUP, UPDATE, RESP};
  - the default DEPTH and DATA_W constants;
  - the response struct type (hit, index, evict_valid, evict_data).
- Sub-module lru_cam_entry, one instance per position, replicated by generate. It contains:
  - a data register and a valid bit;
  - an equality-and-valid compare output;
  - a load enable selecting either the upstream neighbour's value or the new key;
  - the asynchronous active-low reset.
- The controller holds the FSM, the priority encoder, the per-entry shift/insert enables, eviction capture and occupancy.

Test Plan (DEPTH=4, DATA_W=8):
- Fill: after reset, send 0x11, 0x22, 0x33, 0x44.
  - Each response: hit=0, evict_valid=0.
  - Final array: [44,33,22,11]; occupancy=4.
- Hit-promote: from that array, send 0x22.
  - Response: hit=1, index=2.
  - Array becomes [22,44,33,11]; occupancy stays 4.
- Evict: from that array, send 0x55.
  - Response: hit=0, evict_valid=1, evict_data=0x11.
  - Array becomes [55,22,44,33].
- Backpressure: hold resp_ready=0 for 5 cycles.
  - resp_* stay stable and req_ready stays 0.
  - A req_valid pulse in that window is not accepted.
  - Release resp_ready: return to IDLE in 1 cycle.
- Reset mid-operation: assert reset while in UPDATE.
  - All outputs go to their reset values immediately.
  - occupancy=0; the next lookup of a previously stored key misses.
- With LRU_CAM_FLUSH_EN: flush in IDLE sets occupancy=0; a following 0x55 lookup gives hit=0 and evict_valid=0.

Source files
------------

// File: rtl/lru_cam_pkg.sv
// Shared types and defaults for the LRU content-addressable store controller.
package lru_cam_pkg;

  localparam int LRU_DEPTH  = 8;
  localparam int LRU_DATA_W = 8;

  // Response fields are held at fixed maximum widths so one type serves every
  // DEPTH/DATA_W configuration; the controller narrows them at its ports.
  localparam int RESP_IDX_MAX  = 16;
  localparam int RESP_DATA_MAX = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    UPDATE = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic                     hit;
    logic [RESP_IDX_MAX-1:0]  index;
    logic                     evict_valid;
    logic [RESP_DATA_MAX-1:0] evict_data;
  } resp_t;

endpackage

// File: rtl/lru_cam_ctrl_if.sv
// Request/response bus of the LRU CAM controller plus its occupancy status.
interface lru_cam_ctrl_if
  import lru_cam_pkg::*;
#(
  parameter int DEPTH  = LRU_DEPTH,
  parameter int DATA_W = LRU_DATA_W
) ();
  localparam int IDX_W = $clog2(DEPTH);

  // Both channels: a transfer happens on a rising clk edge where valid && ready;
  // the source holds valid and its payload stable until that edge, and valid
  // never waits on ready.
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_hit;
  logic [IDX_W-1:0]  resp_index;
  logic              resp_evict_valid;
  logic [DATA_W-1:0] resp_evict_data;
  logic [IDX_W:0]    occupancy;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_index,
    input  resp_evict_valid, resp_evict_data, occupancy
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_index,
    output resp_evict_valid, resp_evict_data, occupancy
  );

endinterface

// File: rtl/lru_cam_entry.sv
// One CAM position: key register, valid bit and equality-and-valid compare.
module lru_cam_entry #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              sel_key_i,
  input  logic              clr_valid_i,
  input  logic [DATA_W-1:0] key_i,
  input  logic [DATA_W-1:0] up_data_i,
  input  logic              up_valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              match_o
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clr_valid_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= sel_key_i ? key_i : up_data_i;
      valid_q <= sel_key_i ? 1'b1  : up_valid_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign match_o = valid_q && (data_q == key_i);

endmodule

// File: rtl/lru_cam_ctrl.sv
// LRU CAM controller: FSM, priority encoder, shift/insert enables, eviction and occupancy.
// Optional macro LRU_CAM_FLUSH_EN adds a flush input that invalidates every entry from IDLE.
module lru_cam_ctrl
  import lru_cam_pkg::*;
#(
  parameter int DEPTH  = LRU_DEPTH,
  parameter int DATA_W = LRU_DATA_W
) (
  input  logic          clk,
  input  logic          reset,
`ifdef LRU_CAM_FLUSH_EN
  input  logic          flush,
`endif
  lru_cam_ctrl_if.slave bus,
  output state_e        state_o
);
  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] key_q;
  logic              hit_q;
  logic [IDX_W-1:0]  hit_idx_q;
  resp_t             resp_q, resp_d;
  logic [IDX_W:0]    occ_q;

  logic [DATA_W-1:0] data_w [DEPTH];
  logic [DEPTH-1:0]  valid_w, match_w, load_en;
  logic              hit_c;
  logic [IDX_W-1:0]  idx_c;
  logic              flush_c, accept_c, resp_done_c;

`ifdef LRU_CAM_FLUSH_EN
  assign flush_c = (state_q == IDLE) && flush;
`else
  assign flush_c = 1'b0;
`endif
  assign accept_c    = bus.req_valid && bus.req_ready;
  assign resp_done_c = bus.resp_valid && bus.resp_ready;

  // Position 0 takes the key; every other position takes its upstream neighbour.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [DATA_W-1:0] up_data;
    logic              up_valid;
    if (i == 0) begin : g_head
      assign up_data  = '0;
      assign up_valid = 1'b0;
    end else begin : g_body
      assign up_data  = data_w[i-1];
      assign up_valid = valid_w[i-1];
    end
    lru_cam_entry #(.DATA_W(DATA_W)) u_entry (
      .clk         (clk),
      .reset       (reset),
      .load_i      (load_en[i]),
      .sel_key_i   (i == 0),
      .clr_valid_i (flush_c),
      .key_i       (key_q),
      .up_data_i   (up_data),
      .up_valid_i  (up_valid),
      .data_o      (data_w[i]),
      .valid_o     (valid_w[i]),
      .match_o     (match_w[i])
    );
  end

  // Lowest matching position wins.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_w[i]) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c)    state_d = LOOKUP;
      LOOKUP:                   state_d = UPDATE;
      UPDATE:                   state_d = RESP;
      RESP:    if (resp_done_c) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE) && !flush_c;
    bus.resp_valid = (state_q == RESP);
    load_en        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      load_en[i] = (state_q == UPDATE) && (!hit_q || (IDX_W'(i) <= hit_idx_q));
    end
  end

  // Entries still hold their pre-update values in UPDATE, so the last one is the victim.
  always_comb begin
    resp_d = resp_q;
    if (state_q == UPDATE) begin
      resp_d.hit         = hit_q;
      resp_d.index       = RESP_IDX_MAX'(hit_idx_q);
      resp_d.evict_valid = !hit_q && valid_w[DEPTH-1];
      resp_d.evict_data  = hit_q ? '0 : RESP_DATA_MAX'(data_w[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q     <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      resp_q    <= '0;
      occ_q     <= '0;
    end else begin
      resp_q <= resp_d;
      if (accept_c) key_q <= bus.req_data;
      if (state_q == LOOKUP) begin
        hit_q     <= hit_c;
        hit_idx_q <= idx_c;
      end
      if (flush_c) begin
        occ_q <= '0;
      end else if ((state_q == UPDATE) && !hit_q && (occ_q != (IDX_W+1)'(DEPTH))) begin
        occ_q <= occ_q + 1'b1;
      end
    end
  end

  assign bus.resp_hit         = resp_q.hit;
  assign bus.resp_index       = IDX_W'(resp_q.index);
  assign bus.resp_evict_valid = resp_q.evict_valid;
  assign bus.resp_evict_data  = DATA_W'(resp_q.evict_data);
  assign bus.occupancy        = occ_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_lru_cam_ctrl.sv
// Bench for lru_cam_ctrl (DEPTH=4): directed test-plan steps plus random lookups
// scored against a queue-based LRU model. Flush steps exist when LRU_CAM_FLUSH_EN is defined.
module tb_lru_cam_ctrl;
  import lru_cam_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int RW     = 1 + IDX_W + 1 + DATA_W;

  typedef struct {
    logic [DATA_W-1:0] d;
    bit                v;
  } ent_t;

  logic   clk   = 1'b0;
  logic   reset = 1'b0;
`ifdef LRU_CAM_FLUSH_EN
  logic   flush = 1'b0;
`endif
  state_e state;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t          ent_q[$];
  logic [RW-1:0] exp_q[$];
  int            exp_occ;

  logic              r_hit;
  logic [IDX_W-1:0]  r_idx;
  logic              r_ev;
  logic [DATA_W-1:0] r_evd;

  lru_cam_ctrl_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  lru_cam_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef LRU_CAM_FLUSH_EN
    .flush   (flush),
`endif
    .bus     (bus),
    .state_o (state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a list ordered most-recent first, always DEPTH long.
  task automatic model_reset();
    ent_t e;
    e.d = '0;
    e.v = 1'b0;
    ent_q.delete();
    for (int i = 0; i < DEPTH; i++) ent_q.push_back(e);
    exp_occ = 0;
  endtask

  task automatic model_req(input logic [DATA_W-1:0] key);
    bit                hit  = 1'b0;
    int                idx  = 0;
    bit                ev_v = 1'b0;
    logic [DATA_W-1:0] ev_d = '0;
    ent_t              e;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && ent_q[i].v && (ent_q[i].d == key)) begin
        hit = 1'b1;
        idx = i;
      end
    end
    if (hit) begin
      ent_q.delete(idx);
    end else begin
      e    = ent_q.pop_back();
      ev_v = e.v;
      ev_d = e.d;
    end
    e.d = key;
    e.v = 1'b1;
    ent_q.push_front(e);
    exp_q.push_back({hit, IDX_W'(idx), ev_v, ev_d});
    exp_occ = 0;
    foreach (ent_q[i]) if (ent_q[i].v) exp_occ++;
  endtask

  task automatic check_resp(input string tag, input logic [RW-1:0] exp);
    check({tag, "_hit"},         32'(bus.resp_hit),         32'(exp[RW-1]));
    check({tag, "_index"},       32'(bus.resp_index),       32'(exp[RW-2 -: IDX_W]));
    check({tag, "_evict_valid"}, 32'(bus.resp_evict_valid), 32'(exp[DATA_W]));
    if (!exp[RW-1])
      check({tag, "_evict_data"}, 32'(bus.resp_evict_data), 32'(exp[DATA_W-1:0]));
  endtask

  // Driver tasks: called just after a rising edge; they return just after one.
  task automatic accept(input logic [DATA_W-1:0] key, input bit track);
    int cyc = 0;
    bus.req_valid = 1'b1;
    bus.req_data  = key;
    while (!bus.req_ready && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("accept_in_time", 32'(cyc < 16), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (track) model_req(key);
    check("busy_after_accept", 32'(bus.req_ready), 32'd0);
    check("state_lookup", 32'(state), 32'(LOOKUP));
  endtask

  task automatic finish_resp(input int hold, input bit pulse);
    int            cyc = 0;
    logic [RW-1:0] exp;
    @(posedge clk); #1;
    check("resp_not_early", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    while (!bus.resp_valid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("resp_latency", 32'(cyc), 32'd0);
    exp   = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    r_hit = bus.resp_hit;
    r_idx = bus.resp_index;
    r_ev  = bus.resp_evict_valid;
    r_evd = bus.resp_evict_data;
    check_resp("resp", exp);
    check("occupancy", 32'(bus.occupancy), 32'(exp_occ));
    check("busy_in_resp", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = pulse && (i == 1);
      bus.req_data  = 8'hA5;
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
      check_resp("hold", exp);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("released_idle", 32'(state), 32'(IDLE));
    check("released_ready", 32'(bus.req_ready), 32'd1);
    check("released_valid", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic send(input logic [DATA_W-1:0] key, input int hold, input bit pulse);
    accept(key, 1'b1);
    finish_resp(hold, pulse);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},       32'(state),                32'(IDLE));
    check({tag, "_req_ready"},   32'(bus.req_ready),        32'd1);
    check({tag, "_resp_valid"},  32'(bus.resp_valid),       32'd0);
    check({tag, "_hit"},         32'(bus.resp_hit),         32'd0);
    check({tag, "_index"},       32'(bus.resp_index),       32'd0);
    check({tag, "_evict_valid"}, 32'(bus.resp_evict_valid), 32'd0);
    check({tag, "_evict_data"},  32'(bus.resp_evict_data),  32'd0);
    check({tag, "_occupancy"},   32'(bus.occupancy),        32'd0);
  endtask

`ifdef LRU_CAM_FLUSH_EN
  task automatic do_flush();
    flush         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_data  = DATA_W'($urandom_range(0, 9));
    #1;
    check("flush_blocks_req", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    foreach (ent_q[i]) ent_q[i].v = 1'b0;
    exp_occ = 0;
    check("flush_occupancy", 32'(bus.occupancy), 32'd0);
    check("flush_state", 32'(state), 32'(IDLE));
  endtask
`endif

  initial begin
    logic [DATA_W-1:0] fill_keys [4];
    fill_keys[0] = 8'h11;
    fill_keys[1] = 8'h22;
    fill_keys[2] = 8'h33;
    fill_keys[3] = 8'h44;

    bus.req_valid  = 1'b0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    model_reset();

    // Reset
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill an empty array
    for (int i = 0; i < 4; i++) begin
      send(fill_keys[i], 0, 1'b0);
      check("fill_hit", 32'(r_hit), 32'd0);
      check("fill_evict_valid", 32'(r_ev), 32'd0);
    end
    check("fill_occupancy", 32'(bus.occupancy), 32'd4);

    // Hit in the middle promotes to the front
    send(8'h22, 0, 1'b0);
    check("promote_hit", 32'(r_hit), 32'd1);
    check("promote_index", 32'(r_idx), 32'd2);
    check("promote_occupancy", 32'(bus.occupancy), 32'd4);

    // Miss on a full array evicts the oldest, with backpressure and a stray request
    send(8'h55, 5, 1'b1);
    check("evict_hit", 32'(r_hit), 32'd0);
    check("evict_valid", 32'(r_ev), 32'd1);
    check("evict_data", 32'(r_evd), 32'h11);

    // Array is now [55,22,44,33]: the oldest surviving key sits in the last slot
    send(8'h33, 0, 1'b0);
    check("last_slot_hit", 32'(r_hit), 32'd1);
    check("last_slot_index", 32'(r_idx), 32'd3);

    // Reset while in UPDATE abandons the operation
    accept(8'h44, 1'b0);
    @(posedge clk); #1;
    check("state_update", 32'(state), 32'(UPDATE));
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    send(8'h55, 0, 1'b0);
    check("post_reset_hit", 32'(r_hit), 32'd0);
    check("post_reset_evict", 32'(r_ev), 32'd0);

    // Key 0 is an ordinary key; a hit at position 0 leaves the order intact
    send(8'h00, 0, 1'b0);
    check("key0_miss", 32'(r_hit), 32'd0);
    send(8'h00, 1, 1'b0);
    check("key0_hit", 32'(r_hit), 32'd1);
    check("key0_index", 32'(r_idx), 32'd0);
    check("key0_occupancy", 32'(bus.occupancy), 32'd2);

`ifdef LRU_CAM_FLUSH_EN
    do_flush();
    send(8'h55, 0, 1'b0);
    check("flush_then_hit", 32'(r_hit), 32'd0);
    check("flush_then_evict", 32'(r_ev), 32'd0);
`endif

    // Random lookups over a small key space so hits and evictions both occur
    for (int n = 0; n < 60; n++) begin
`ifdef LRU_CAM_FLUSH_EN
      if ($urandom_range(0, 15) == 0) do_flush();
`endif
      send(DATA_W'($urandom_range(0, 9)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
